ex_sequencer: RTL and testbench

//  Control and sequencing unit for the execute stage.

---
 rtl/musa_ex_pkg.sv | 48 ++++
 rtl/ex_muldiv_iter.sv | 80 ++++++++
 rtl/ex_sequencer.sv | 142 ++++++++++++++
 tb/tb_ex_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/musa_ex_pkg.sv
// Shared definitions for the execute-stage sequencer.
// Contents: opcode/func field values, alu_control codes, pc_select codes,
// MUL/DIV FSM state encoding and a helper that spots MUL/DIV instructions.
package musa_ex_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_RET   = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MUL   = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_SLT    = 3'd4;
  localparam logic [2:0] ALU_PASS_B = 3'd5;

  localparam logic [2:0] PC_NEXT   = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_REG_A  = 3'd3;
  localparam logic [2:0] PC_STACK  = 3'd4;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [5:0] opcode, input logic [5:0] func);
    return (opcode == OP_RTYPE) && ((func == FN_MUL) || (func == FN_DIV));
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned MUL/DIV datapath, one iteration per step.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   start             latch operands and operation, clear accumulator/counter
//   step              perform one iteration (FSM is in RUN)
//   is_div            operation select at start: 0 MUL, 1 DIV
//   op_a, op_b        multiplicand/dividend, multiplier/divisor
//   result            low product or quotient (valid after MD_ITER steps)
//   last              the current step is the final iteration
module ex_muldiv_iter #(
  parameter int WIDTH   = 32,
  parameter int MD_ITER = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  localparam int CNT_W = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;

  logic [WIDTH-1:0] b_q;     // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc;     // product high half (MUL) or remainder (DIV)
  logic [WIDTH-1:0] mq;      // multiplier->product low (MUL) or dividend->quotient (DIV)
  logic [CNT_W-1:0] count;
  logic             is_div_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;

  // MUL: conditional add into the high half; the carry becomes the new top bit
  // when {acc,mq} shifts right.
  assign add_sum  = {1'b0, acc} + {1'b0, (mq[0] ? b_q : '0)};
  // DIV: remainder never exceeds the divisor, so the subtraction fits in WIDTH
  // bits whenever rem_ge holds. A zero divisor always subtracts, giving all-ones.
  assign rem_sh   = {acc, mq[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, b_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - b_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_q      <= '0;
      acc      <= '0;
      mq       <= '0;
      count    <= '0;
      is_div_q <= 1'b0;
    end else if (start) begin
      b_q      <= op_b;
      acc      <= '0;
      mq       <= op_a;
      count    <= '0;
      is_div_q <= is_div;
    end else if (step) begin
      count <= count + CNT_W'(1);
      if (is_div_q) begin
        if (rem_ge) begin
          acc <= rem_diff;
          mq  <= {mq[WIDTH-2:0], 1'b1};
        end else begin
          acc <= rem_sh[WIDTH-1:0];
          mq  <= {mq[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= add_sum[WIDTH:1];
        mq  <= {add_sum[0], mq[WIDTH-1:1]};
      end
    end
  end

  assign result = mq;
  assign last   = (count == CNT_W'(MD_ITER - 1));

endmodule

// File: rtl/ex_sequencer.sv
// Execute-stage control: instruction decode into EX datapath controls, branch
// resolution from EX flags, and sequencing of iterative MUL/DIV with pipeline stall.
// Ports:
//   clock, reset                     rising-edge clock, async active-high reset
//   issue_valid, opcode, func        instruction presented by ID/EX
//   flag                             EX flags {ovf,neg,zero}
//   flush                            squash EX instruction / abort MUL/DIV
//   operand_a, operand_b             MUL/DIV operands
//   alu_control, data_a_select,
//   data_b_select, pc_select         EX datapath controls
//   stall, busy                      pipeline hold / MUL/DIV engine active
//   md_valid, md_result              MUL/DIV completion pulse and result
//
// state   | meaning
// --------+---------------------------------------------------------------
// MD_IDLE | decoding issued instructions; MUL/DIV may start
// MD_RUN  | one MUL/DIV iteration per cycle, pipeline stalled
// MD_DONE | result presented with md_valid; back to IDLE next cycle
module ex_sequencer
  import musa_ex_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MD_ITER = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic [2:0]       flag,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [2:0]       alu_control,
  output logic             data_a_select,
  output logic             data_b_select,
  output logic [2:0]       pc_select,
  output logic             stall,
  output logic             busy,
  output logic             md_valid,
  output logic [WIDTH-1:0] md_result
);

  md_state_t        state_q, state_d;
  logic             decode_en;
  logic             md_start;
  logic             md_last;
  logic [WIDTH-1:0] eng_result;
  logic [WIDTH-1:0] md_result_q;
  logic             unused_flags;

  // Only the zero flag takes part in branch resolution.
  assign unused_flags = &{1'b0, flag[2:1]};

  // Outputs are forced to their reset values while reset is held.
  assign decode_en = issue_valid & ~flush & ~reset & (state_q == MD_IDLE);
  assign md_start  = decode_en & is_muldiv(opcode, func);

  always_comb begin
    alu_control   = ALU_ADD;
    data_a_select = 1'b0;
    data_b_select = 1'b0;
    pc_select     = PC_NEXT;
    if (decode_en) begin
      case (opcode)
        OP_RTYPE: begin
          case (func)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_JR:   pc_select   = PC_REG_A;
            default: ;
          endcase
        end
        OP_ADDI, OP_LW, OP_SW: data_b_select = 1'b1;
        OP_BEQ: begin
          alu_control = ALU_SUB;
          pc_select   = flag[0] ? PC_BRANCH : PC_NEXT;
        end
        OP_BNE: begin
          alu_control = ALU_SUB;
          pc_select   = flag[0] ? PC_NEXT : PC_BRANCH;
        end
        OP_J:   pc_select = PC_JUMP;
        OP_JAL: begin
          pc_select     = PC_JUMP;
          data_a_select = 1'b1;
        end
        OP_RET: pc_select = PC_STACK;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (md_start) state_d = MD_RUN;
      MD_RUN: begin
        if (flush)        state_d = MD_IDLE;
        else if (md_last) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  ex_muldiv_iter #(
    .WIDTH   (WIDTH),
    .MD_ITER (MD_ITER)
  ) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .start  (md_start),
    .step   (state_q == MD_RUN),
    .is_div (func == FN_DIV),
    .op_a   (operand_a),
    .op_b   (operand_b),
    .result (eng_result),
    .last   (md_last)
  );

  // The engine result is shown directly in DONE and captured at the end of it;
  // a flush during DONE therefore leaves the visible result untouched.
  assign md_valid  = (state_q == MD_DONE) & ~flush;
  assign md_result = md_valid ? eng_result : md_result_q;
  assign stall     = md_start | (state_q == MD_RUN);
  assign busy      = (state_q != MD_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         md_result_q <= '0;
    else if (md_valid) md_result_q <= eng_result;
  end

endmodule

// File: tb/tb_ex_sequencer.sv
module tb_ex_sequencer;
  import musa_ex_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [2:0]  flag;
  logic        flush;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [2:0]  alu_control;
  logic        data_a_select;
  logic        data_b_select;
  logic [2:0]  pc_select;
  logic        stall;
  logic        busy;
  logic        md_valid;
  logic [31:0] md_result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];
  logic [31:0] last_result = 32'd0;

  ex_sequencer #(.WIDTH(32), .MD_ITER(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .opcode        (opcode),
    .func          (func),
    .flag          (flag),
    .flush         (flush),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .alu_control   (alu_control),
    .data_a_select (data_a_select),
    .data_b_select (data_b_select),
    .pc_select     (pc_select),
    .stall         (stall),
    .busy          (busy),
    .md_valid      (md_valid),
    .md_result     (md_result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every md_valid pulse must match the oldest expected op.
  always @(negedge clock) begin
    #1;
    if (md_valid === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL md_unexpected: got md_valid=1 result %h want no pulse (cycle %0d)", md_result, cyc);
      end else begin
        chk("md_result", md_result, exp_res_q.pop_front());
        chk("md_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // Reference decode from the instruction table: {alu, a_sel, b_sel, pc}.
  function automatic logic [7:0] ref_dec(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] fl);
    logic [2:0] alu = 3'd0;
    logic       a   = 1'b0;
    logic       b   = 1'b0;
    logic [2:0] pc  = 3'd0;
    if (op == 6'h00) begin
      if (fn == 6'h20) alu = 3'd0;
      if (fn == 6'h22) alu = 3'd1;
      if (fn == 6'h24) alu = 3'd2;
      if (fn == 6'h25) alu = 3'd3;
      if (fn == 6'h2A) alu = 3'd4;
      if (fn == 6'h08) pc  = 3'd3;
    end
    if (op == 6'h08 || op == 6'h23 || op == 6'h2B) b = 1'b1;
    if (op == 6'h04) begin alu = 3'd1; pc = fl[0] ? 3'd1 : 3'd0; end
    if (op == 6'h05) begin alu = 3'd1; pc = fl[0] ? 3'd0 : 3'd1; end
    if (op == 6'h02) pc = 3'd2;
    if (op == 6'h03) begin pc = 3'd2; a = 1'b1; end
    if (op == 6'h3F) pc = 3'd4;
    return {alu, a, b, pc};
  endfunction

  task automatic dec_chk(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] fl);
    @(negedge clock);
    issue_valid = 1'b1; opcode = op; func = fn; flag = fl;
    #1;
    chk($sformatf("decode op%h fn%h fl%b", op, fn, fl),
        {24'd0, alu_control, data_a_select, data_b_select, pc_select}, {24'd0, ref_dec(op, fn, fl)});
    chk("decode_no_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic md_op(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_v;
    int          n;
    int          t0;
    if (is_div) exp_v = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    else        exp_v = a * b;
    @(negedge clock);
    issue_valid = 1'b1; opcode = 6'h00; func = is_div ? 6'h1A : 6'h18;
    operand_a = a; operand_b = b; flag = 3'($urandom_range(0, 7));
    #1;
    chk("md_stall_at_issue", {31'd0, stall}, 32'd1);
    t0 = cyc;
    exp_res_q.push_back(exp_v);
    exp_cyc_q.push_back(t0 + 33);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 0) begin
        // Upstream may keep presenting something while stalled; it must be ignored,
        // and changing the operands must not disturb the latched ones.
        opcode = 6'h08; operand_a = $urandom; operand_b = $urandom;
      end
      #1;
      if (i == 0) begin
        chk("run_decode_masked", {29'd0, alu_control, data_b_select}, 32'd0);
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_md_hold", md_result, last_result);
      end
      if (stall) n++;
      else begin
        chk("done_decode_masked", {31'd0, data_b_select}, 32'd0);
        issue_valid = 1'b0;
        break;
      end
    end
    issue_valid = 1'b0;
    chk("stall_cycles", n, 33);
    last_result = exp_v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion (cycle %0d)", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  ops[10];
    logic [5:0]  fns[7];
    logic [5:0]  op, fn;
    logic [31:0] ra, rb;

    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h3F, 6'h11};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h3C};

    reset = 1'b1; issue_valid = 1'b0; opcode = '0; func = '0; flag = '0;
    flush = 1'b0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_outputs", {alu_control, data_a_select, data_b_select, pc_select, stall, busy, md_valid},
        {3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    chk("reset_md_result", md_result, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed decode cases
    dec_chk(6'h08, 6'h00, 3'b000);
    dec_chk(6'h04, 6'h00, 3'b001);
    dec_chk(6'h04, 6'h00, 3'b000);
    dec_chk(6'h05, 6'h00, 3'b001);
    dec_chk(6'h05, 6'h00, 3'b000);
    dec_chk(6'h03, 6'h00, 3'b110);

    // Random decode
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 9)];
      fn = fns[$urandom_range(0, 6)];
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
      if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) fn = 6'h20;
      dec_chk(op, fn, 3'($urandom_range(0, 7)));
    end
    @(negedge clock);
    issue_valid = 1'b0;

    // Directed MUL/DIV
    md_op(1'b0, 32'd123456, 32'd789);
    md_op(1'b1, 32'd100, 32'd7);
    md_op(1'b1, 32'd100, 32'd0);
    md_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Random MUL/DIV
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      md_op(1'($urandom_range(0, 1)), ra, rb);
    end

    // Flush at T+5 aborts a MUL
    @(negedge clock);
    issue_valid = 1'b1; opcode = 6'h00; func = 6'h18;
    operand_a = 32'd55; operand_b = 32'd66;
    repeat (5) begin
      @(negedge clock);
      issue_valid = 1'b0;
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_md_valid", {31'd0, md_valid}, 32'd0);
    chk("flush_md_hold", md_result, last_result);
    repeat (40) @(negedge clock);

    // Flush in the issue cycle: op never starts
    @(negedge clock);
    issue_valid = 1'b1; opcode = 6'h00; func = 6'h1A; flush = 1'b1;
    #1;
    chk("flushT_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    issue_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flushT_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clock);

    // One more op so the result register holds a nonzero value, then reset mid-DIV
    md_op(1'b0, 32'd3, 32'd5);
    @(negedge clock);
    issue_valid = 1'b1; opcode = 6'h00; func = 6'h1A;
    operand_a = 32'd1000; operand_b = 32'd9;
    @(negedge clock);
    issue_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_md_valid", {31'd0, md_valid}, 32'd0);
    chk("rst_mid_md_result", md_result, 32'd0);
    last_result = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    // A clean op after reset still works
    md_op(1'b1, 32'd1000, 32'd9);
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", exp_res_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
